uv_arb_rr_hold: RTL and testbench

UV_ARB_RR_HOLD -- requirements
Module: uv_arb_rr_hold

---
 rtl/uv_arb_rr_hold.sv | 112 +++++++++++
 tb/tb_uv_arb_rr_hold.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uv_arb_rr_hold.sv
// Round-robin arbiter with a registered one-hot grant, owner hold limit and
// a mandatory idle cycle between consecutive grants.
module uv_arb_rr_hold #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           req,
  input  logic                       done,
  output logic [WIDTH-1:0]           grant,
  output logic                       grant_vld,
  output logic [$clog2(WIDTH)-1:0]   grant_idx,
  output logic                       timeout
);

  localparam int unsigned IdxW  = $clog2(WIDTH);
  localparam int unsigned HoldW = $clog2(MAX_HOLD);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [WIDTH-1:0]  grant_q, grant_d;
  logic              timeout_q, timeout_d;

  logic              pick_vld;
  logic [IdxW-1:0]   pick_idx;
  logic              hold_at_max;
  logic              owner_req;
  logic [IdxW-1:0]   ptr_next;

  // Wrap-around scan starting at the priority pointer.
  always_comb begin
    int unsigned     j;
    logic [IdxW-1:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      j = 32'(ptr_q) + i;
      if (j >= WIDTH) j = j - WIDTH;
      cand = IdxW'(j);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign hold_at_max = (hold_q == HoldW'(MAX_HOLD - 1));
  assign owner_req   = req[idx_q];
  assign ptr_next    = (idx_q == IdxW'(WIDTH - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d = StBusy;
          grant_d = {{(WIDTH-1){1'b0}}, 1'b1} << pick_idx;
          idx_d   = pick_idx;
          hold_d  = '0;
        end
      end
      StBusy: begin
        if (done || !owner_req || hold_at_max) begin
          state_d   = StIdle;
          grant_d   = '0;
          idx_d     = '0;
          hold_d    = '0;
          ptr_d     = ptr_next;
          // Only a pure hold-limit release is reported as a timeout.
          timeout_d = hold_at_max && !done && owner_req;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign grant_vld = |grant_q;
  assign grant_idx = idx_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_uv_arb_rr_hold.sv
// Bench for uv_arb_rr_hold: directed scenarios, random stress, and a
// cycle-level behavioural model compared on every falling clock edge.
module tb_uv_arb_rr_hold;

  localparam int W  = 4;
  localparam int MH = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] req;
  logic         done;
  logic [W-1:0] grant;
  logic         grant_vld;
  logic [1:0]   grant_idx;
  logic         timeout;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // Model state: owner (-1 = none), cycles the grant has been visible, pointer.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;
  bit m_to    = 0;

  uv_arb_rr_hold #(
    .WIDTH   (W),
    .MAX_HOLD(MH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_vld(grant_vld),
    .grant_idx(grant_idx),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_ptr   = 0;
    m_to    = 0;
  endtask

  // One clock edge of the arbiter's contract, using the inputs seen at that edge.
  task automatic model_edge(input logic [W-1:0] r, input logic d);
    bit found;
    int c;
    if (m_owner >= 0) begin
      if (d || !r[m_owner] || m_cnt == MH) begin
        m_to    = (m_cnt == MH) && !d && r[m_owner];
        m_ptr   = (m_owner + 1) % W;
        m_owner = -1;
      end else begin
        m_cnt++;
        m_to = 0;
      end
    end else begin
      m_to  = 0;
      found = 0;
      for (int k = 0; k < W; k++) begin
        c = (m_ptr + k) % W;
        if (!found && r[c]) begin
          found   = 1;
          m_owner = c;
          m_cnt   = 1;
        end
      end
    end
  endtask

  task automatic step(input logic [W-1:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    if (!rst) model_edge(r, d);
    #1;
  endtask

  always @(negedge clk) begin
    logic [W-1:0] eg;
    if (chk_en) begin
      eg = (m_owner >= 0) ? W'(1) << m_owner : '0;
      chk("model_grant", 32'(grant), 32'(eg));
      chk("model_vld", 32'(grant_vld), 32'(m_owner >= 0));
      chk("model_idx", 32'(grant_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      chk("model_timeout", 32'(timeout), 32'(m_to));
      chk("onehot0", 32'($onehot0(grant)), 32'd1);
      if (grant_vld) chk("idx_consistent", 32'(grant), 32'(W'(1) << grant_idx));
      else           chk("idx_zero", 32'(grant_idx), 32'd0);
    end
  end

  logic [W-1:0] seq [5];
  logic [W-1:0] r_s;
  logic         prev_vld;
  int           waitc [W];

  initial begin
    rst  = 1'b0;
    req  = '0;
    done = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #2;
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_vld", 32'(grant_vld), 32'd0);
    chk("reset_idx", 32'(grant_idx), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    chk_en = 1;
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic grant, done release, pointer advance.
    step(4'b1010, 1'b0);
    chk("b_grant1", 32'(grant), 32'h2);
    chk("b_idx1", 32'(grant_idx), 32'd1);
    step(4'b1010, 1'b1);
    chk("b_gap", 32'(grant), 32'h0);
    step(4'b1010, 1'b0);
    chk("b_grant3", 32'(grant), 32'h8);
    chk("b_idx3", 32'(grant_idx), 32'd3);
    step(4'b0000, 1'b0);
    chk("b_drop", 32'(grant), 32'h0);

    // Full rotation with wrap-around.
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b0);
      chk("rr_grant", 32'(grant), 32'(seq[k]));
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b1);
      chk("rr_gap", 32'(grant), 32'h0);
    end

    // Hold limit forces a release with a timeout pulse.
    step(4'b0100, 1'b0);
    chk("to_grant", 32'(grant), 32'h4);
    for (int k = 0; k < 3; k++) begin
      step(4'b0100, 1'b0);
      chk("to_held", 32'(grant), 32'h4);
      chk("to_nopulse", 32'(timeout), 32'd0);
    end
    step(4'b0100, 1'b0);
    chk("to_release", 32'(grant), 32'h0);
    chk("to_pulse", 32'(timeout), 32'd1);
    step(4'b0100, 1'b0);
    chk("to_regrant", 32'(grant), 32'h4);
    chk("to_pulse_end", 32'(timeout), 32'd0);

    // Owner drops its request.
    step(4'b1011, 1'b0);
    chk("drop_grant", 32'(grant), 32'h0);
    chk("drop_timeout", 32'(timeout), 32'd0);
    step(4'b1011, 1'b0);
    chk("drop_next", 32'(grant), 32'h8);
    step(4'b0000, 1'b0);

    // done coinciding with the hold limit: no timeout.
    step(4'b0110, 1'b0);
    chk("co_grant", 32'(grant), 32'h2);
    step(4'b0110, 1'b0);
    step(4'b0110, 1'b0);
    step(4'b0110, 1'b0);
    step(4'b0110, 1'b1);
    chk("co_release", 32'(grant), 32'h0);
    chk("co_timeout", 32'(timeout), 32'd0);

    // Asynchronous reset mid-grant.
    step(4'b0100, 1'b0);
    chk("ar_grant", 32'(grant), 32'h4);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("ar_grant0", 32'(grant), 32'd0);
    chk("ar_vld0", 32'(grant_vld), 32'd0);
    chk("ar_idx0", 32'(grant_idx), 32'd0);
    chk("ar_to0", 32'(timeout), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(4'b0110, 1'b0);
    chk("ar_after", 32'(grant), 32'h2);

    // done is ignored while idle.
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0001, 1'b1);
    chk("idle_done", 32'(grant), 32'h1);
    step(4'b0000, 1'b0);

    // Random stress with starvation tracking.
    r_s      = '0;
    prev_vld = 1'b0;
    for (int i = 0; i < W; i++) waitc[i] = 0;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(7) == 0) r_s[i] = ~r_s[i];
      step(r_s, ($urandom_range(3) == 0));
      for (int i = 0; i < W; i++) if (!r_s[i]) waitc[i] = 0;
      if (grant_vld && !prev_vld) begin
        for (int i = 0; i < W; i++) begin
          if (i == int'(grant_idx)) waitc[i] = 0;
          else if (r_s[i]) begin
            waitc[i]++;
            chk("starve", 32'(waitc[i] <= W), 32'd1);
          end
        end
      end
      prev_vld = grant_vld;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
